mux_scanner: RTL
================

# mux_scanner

Parametrised, registered N-to-1 channel multiplexer with a valid/ready output stage and an automatic round-robin scan mode. It selects one WIDTH-bit channel out of CHANNELS packed inputs, either on demand from an external select (manual mode) or by sweeping all channels with a programmable dwell time (scan mode). It tags each sample with its channel index and holds it under downstream back-pressure. It sits between parallel status/data sources and a single serial consumer, replacing the single-bit combinational select tree.

## Interface
Parameters:
- CHANNELS, 8, number of input channels (>=2; need not be a power of two)
- WIDTH, 8, bits per channel
- DWELL, 4, scan-mode cycles per channel (>=1)
- SEL_W (localparam), $clog2(CHANNELS), select/index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  CHANNELS*WIDTH  packed channels; channel i = in_data[i*WIDTH +: WIDTH]
- mode  in  1  0 = manual, 1 = scan
- sel  in  SEL_W  manual-mode channel select
- out_ready  in  1  downstream accepts the sample when high with out_valid
- out_data  out  WIDTH  registered sample
- out_ch  out  SEL_W  channel index of out_data
- out_valid  out  1  out_data/out_ch valid
- out_last  out  1  high with a scan-mode sample of channel CHANNELS-1

## Operation
- Internal state: mode_q (registered mode), ch_ptr (SEL_W), dwell_cnt (counts 0..DWELL-1).
- slot_free = !out_valid || out_ready. load = slot_free && due && (mode == mode_q).
- Mode change (mode != mode_q at an edge): mode_q <= mode, ch_ptr <= 0, dwell_cnt <= 0, no load that edge; out_valid is cleared if out_ready, otherwise the pending sample is held.
- Manual: due = 1; source channel = sel. On load: out_data <= ch[sel], out_ch <= sel, out_last <= 0.
- Scan: due = (dwell_cnt == DWELL-1); source channel = ch_ptr. On load: out_data <= ch[ch_ptr], out_ch <= ch_ptr, out_last <= (ch_ptr == CHANNELS-1), ch_ptr <= (ch_ptr == CHANNELS-1) ? 0 : ch_ptr+1, dwell_cnt <= 0.
- Scan, not due: dwell_cnt increments. Scan, due but !slot_free: dwell_cnt and ch_ptr hold (stall); no channel is skipped.
- Out-of-range select (sel >= CHANNELS): out_data <= 0, out_ch <= sel, out_valid still asserts.
- On load, out_valid <= 1. Without a load, out_valid <= 0 when out_ready, otherwise it holds. out_data/out_ch/out_last are stable while out_valid && !out_ready.
- Data is sampled at the loading edge; changes to in_data during dwell are not captured.

## Timing
- Reset (async assert, sync release): out_data = 0, out_ch = 0, out_valid = 0, out_last = 0, ch_ptr = 0, dwell_cnt = 0, mode_q = 0. Reset mid-scan abandons the sweep; the next scan restarts at channel 0.
- Manual latency: sel/in_data at edge N appear on the outputs after edge N. With out_ready held high, there is one sample per cycle.
- Scan latency: the first edge seeing mode = 1 clears the counters. Channel 0 loads DWELL edges later. Steady state with out_ready high is one sample every DWELL cycles. A full sweep takes CHANNELS*DWELL cycles.
- DWELL = 1: a scan sample every cycle; channels 0..CHANNELS-1 appear back-to-back.
- Wrap: after channel CHANNELS-1, the next sample is channel 0 with out_last = 0.
- Simultaneous out_ready and load: the old sample is consumed and the new one is loaded in the same edge; out_valid stays 1.

## Test plan
- CHANNELS=8, WIDTH=8, ch i = 8'h10+i. Reset, then manual mode, out_ready=1, sel=5 -> after one edge out_data=8'h15, out_ch=5, out_valid=1. Outputs stay 0 during reset.
- Manual, sel sweeps 0..7 one per cycle, out_ready=1 -> out_data 8'h10..8'h17 each one cycle late, out_last always 0.
- Scan, DWELL=4, out_ready=1 -> samples ch0..ch7 at 4-cycle spacing, first on the 4th edge after mode rises. out_last=1 only with out_ch=7, then wraps to ch0.
- Scan, drop out_ready for 10 cycles while ch2 is held -> out_data=8'h12 is stable. The next samples after release are ch3, ch4 in order with no skip.
- Scan mid-sweep (ch_ptr=5), assert rst_n=0 asynchronously -> all outputs 0 immediately. On release, the scan restarts from ch0.
- CHANNELS=6, manual sel=7 -> out_data=0, out_ch=7, out_valid=1. Scan-mode wrap goes 5 -> 0.

Source files
------------

// File: rtl/mux_scanner.sv
// mux_scanner: a registered N-to-1 channel multiplexer with a valid/ready
// output stage. It has two modes:
//   - manual mode: the external select picks the channel every cycle.
//   - scan mode: a round-robin sweep that dwells DWELL cycles on each channel.
// Each sample is tagged with its channel index. The sample is held while the
// downstream side back-pressures.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    CHANNELS packed WIDTH-bit channels (channel i at [i*WIDTH +: WIDTH])
//   mode       0 = manual, 1 = scan
//   sel        manual-mode channel select
//   out_ready  downstream accepts the current sample
//   out_data   registered sample
//   out_ch     channel index of out_data
//   out_valid  out_data/out_ch hold a sample
//   out_last   scan-mode sample taken from channel CHANNELS-1
module mux_scanner #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8,
  parameter int DWELL    = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  output logic                      out_last
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic             r_mode_q;
  logic [SEL_W-1:0] r_ch_ptr;
  logic [DW_W-1:0]  r_dwell;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_ch;
  logic             r_valid;
  logic             r_last;

  logic             w_mode_chg;
  logic             w_slot_free;
  logic             w_due;
  logic             w_load;
  logic             w_ptr_end;
  logic [SEL_W-1:0] w_src_sel;
  logic [WIDTH-1:0] w_src_data;

  assign w_mode_chg  = (mode != r_mode_q);
  assign w_slot_free = !r_valid || out_ready;
  assign w_due       = r_mode_q ? (r_dwell == DW_W'(DWELL - 1)) : 1'b1;
  // The first edge after a mode change only resets the sweep state.
  // No sample is loaded on that edge.
  assign w_load      = w_slot_free && w_due && !w_mode_chg;
  assign w_ptr_end   = (r_ch_ptr == SEL_W'(CHANNELS - 1));
  assign w_src_sel   = r_mode_q ? r_ch_ptr : sel;

  // Select by equality compare so that an out-of-range select (possible when
  // CHANNELS is not a power of two) matches no channel and yields zero.
  always_comb begin
    w_src_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_src_sel == SEL_W'(i)) w_src_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q <= 1'b0;
      r_ch_ptr <= '0;
      r_dwell  <= '0;
      r_data   <= '0;
      r_ch     <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      if (w_mode_chg) begin
        r_mode_q <= mode;
        r_ch_ptr <= '0;
        r_dwell  <= '0;
      end else if (r_mode_q) begin
        if (!w_due) begin
          r_dwell <= r_dwell + 1'b1;
        end else if (w_slot_free) begin
          r_dwell  <= '0;
          r_ch_ptr <= w_ptr_end ? '0 : r_ch_ptr + 1'b1;
        end
        // due but slot busy: hold the pointer and counter so no channel is skipped
      end

      if (w_load) begin
        r_data  <= w_src_data;
        r_ch    <= w_src_sel;
        r_last  <= r_mode_q && w_ptr_end;
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_valid = r_valid;
  assign out_last  = r_last;

endmodule
